// File: rtl/oled_disp_ctrl_if.sv
// Purpose : sensor-data and OLED-stage signal bundle for oled_disp_ctrl.
// Latency : wires only, no storage.
// Backpressure: none here; pacing is done by the controller against done_init/done_send_data.
// master : environment side (sensor reading, OLED stage handshake in; display data/triggers out)
// slave  : controller side (mirror of master)
interface oled_disp_ctrl_if;
    logic       sensor_valid;
    logic [7:0] s_I_Temp, s_D_Temp, s_I_RH, s_D_RH;
    logic       done_init;
    logic       done_send_data;
    logic [1:0] mode;
    logic       trig_newd0, trig_newd12;
    logic [7:0] I_Temp, D_Temp, I_RH, D_RH;
    logic [7:0] I_Temp_war, I_Hum_war;
    logic       busy;

    modport master (
        output sensor_valid, s_I_Temp, s_D_Temp, s_I_RH, s_D_RH, done_init, done_send_data,
        input  mode, trig_newd0, trig_newd12, I_Temp, D_Temp, I_RH, D_RH,
               I_Temp_war, I_Hum_war, busy
    );

    modport slave (
        input  sensor_valid, s_I_Temp, s_D_Temp, s_I_RH, s_D_RH, done_init, done_send_data,
        output mode, trig_newd0, trig_newd12, I_Temp, D_Temp, I_RH, D_RH,
               I_Temp_war, I_Hum_war, busy
    );
endinterface

// File: rtl/oled_disp_ctrl.sv
// Purpose : OLED display update controller: button handling, thresholds, paced refresh triggers.
// Latency : sensor_valid -> trigger 2 edges; button -> action 3 cycles (+DEB_CYC when debounced).
// Backpressure: one transfer outstanding; next trigger waits for done_send_data rise (or timeout) + HOLD_CYC.
// Ports: clk, rst_n (async active-low), btn_mode/btn_up/btn_down (raw async buttons),
//        bus (oled_disp_ctrl_if.slave: sensor reading, OLED handshake, display outputs).
// Build option: OLED_CTRL_DEBOUNCE_EN adds per-button stable-time counters (DEB_CYC clocks).
module oled_disp_ctrl #(
    parameter int DEB_CYC       = 1_000_000,
    parameter int HOLD_CYC      = 10_000_000,
    parameter int TIMEOUT_CYC   = 50_000_000,
    parameter int TEMP_WAR_INIT = 35,
    parameter int TEMP_WAR_MAX  = 60,
    parameter int HUM_WAR_INIT  = 80,
    parameter int HUM_WAR_MAX   = 99
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_mode,
    input  logic             btn_up,
    input  logic             btn_down,
    oled_disp_ctrl_if.slave  bus
);
    // One counter width serves every counter: sized for the largest cycle parameter.
    localparam int CNT_MAX_A = (HOLD_CYC > TIMEOUT_CYC) ? HOLD_CYC : TIMEOUT_CYC;
    localparam int CNT_MAX   = (DEB_CYC > CNT_MAX_A) ? DEB_CYC : CNT_MAX_A;
    localparam int CW        = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    TMAX      = 8'(TEMP_WAR_MAX);
    localparam logic [7:0]    HMAX      = 8'(HUM_WAR_MAX);

    typedef enum logic [1:0] {IDLE, TRIG, BUSY, HOLD} state_t;

    // ---------------- buttons: bit0 mode, bit1 up, bit2 down ----------------
    logic [2:0] btn_raw, sync1_q, sync2_q, edge_ref_q, btn_lvl, btn_pulse;
    assign btn_raw = {btn_down, btn_up, btn_mode};

`ifdef OLED_CTRL_DEBOUNCE_EN
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);
    logic [2:0]    stable_q;
    logic [CW-1:0] deb_cnt_q [3];

    // A new level is adopted only after it has differed from the stable one for DEB_CYC clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_LAST) begin
                    stable_q[i]  <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end
    assign btn_lvl = stable_q;
`else
    assign btn_lvl = sync2_q;
`endif

    assign btn_pulse = btn_lvl & ~edge_ref_q;

    // ---------------- mode request, thresholds ----------------
    logic [1:0]  mode_req_q, mode_req_d, mode_q;
    logic [7:0]  temp_war_q, temp_war_d, hum_war_q, hum_war_d;
    logic        adj_up, adj_dn, thr_chg;

    // Simultaneous up and down cancel each other.
    assign adj_up = btn_pulse[1] & ~btn_pulse[2];
    assign adj_dn = btn_pulse[2] & ~btn_pulse[1];

    always_comb begin
        mode_req_d = mode_req_q;
        temp_war_d = temp_war_q;
        hum_war_d  = hum_war_q;
        if (btn_pulse[0]) mode_req_d = (mode_req_q == 2'd2) ? 2'd0 : mode_req_q + 2'd1;
        // Thresholds follow the mode currently on the display.
        if (mode_q == 2'd1) begin
            if (adj_up && temp_war_q < TMAX)  temp_war_d = temp_war_q + 8'd1;
            if (adj_dn && temp_war_q != 8'd0) temp_war_d = temp_war_q - 8'd1;
        end else if (mode_q == 2'd2) begin
            if (adj_up && hum_war_q < HMAX)   hum_war_d = hum_war_q + 8'd1;
            if (adj_dn && hum_war_q != 8'd0)  hum_war_d = hum_war_q - 8'd1;
        end
    end
    assign thr_chg = (temp_war_d != temp_war_q) || (hum_war_d != hum_war_q);

    // ---------------- sensor shadow ----------------
    logic [31:0] shadow_q, disp_q;   // {I_Temp, D_Temp, I_RH, D_RH}
    logic        sv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            edge_ref_q <= '0;
            mode_req_q <= 2'd0;
            temp_war_q <= 8'(TEMP_WAR_INIT);
            hum_war_q  <= 8'(HUM_WAR_INIT);
            shadow_q   <= '0;
            sv_q       <= 1'b0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            edge_ref_q <= btn_lvl;
            mode_req_q <= mode_req_d;
            temp_war_q <= temp_war_d;
            hum_war_q  <= hum_war_d;
            sv_q       <= bus.sensor_valid;
            if (bus.sensor_valid)
                shadow_q <= {bus.s_I_Temp, bus.s_D_Temp, bus.s_I_RH, bus.s_D_RH};
        end
    end

    // ---------------- refresh FSM ----------------
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          pending_q, done_q, trig0_q, trig12_q;
    logic          done_rise, timeout_hit, sensor_diff, pend_set;

    assign done_rise   = bus.done_send_data & ~done_q;
    assign timeout_hit = (state_q == BUSY) && !done_rise && (cnt_q == TO_LAST);
    // Compared one cycle after the strobe, once the shadow holds the new reading.
    assign sensor_diff = sv_q && (shadow_q != disp_q);
    assign pend_set    = btn_pulse[0] | thr_chg | sensor_diff | timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b1;
            mode_q    <= 2'd0;
            disp_q    <= '0;
            trig0_q   <= 1'b0;
            trig12_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            trig0_q  <= 1'b0;
            trig12_q <= 1'b0;
            done_q   <= bus.done_send_data;
            if (pend_set) pending_q <= 1'b1;
            case (state_q)
                IDLE: if (pending_q && bus.done_init) begin
                    mode_q   <= mode_req_q;
                    disp_q   <= shadow_q;
                    if (!pend_set) pending_q <= 1'b0;   // a new event this cycle survives
                    trig0_q  <= (mode_req_q == 2'd0);
                    trig12_q <= (mode_req_q != 2'd0);
                    cnt_q    <= '0;
                    state_q  <= TRIG;
                end
                TRIG: begin
                    cnt_q   <= '0;
                    state_q <= BUSY;
                end
                BUSY: if (done_rise || cnt_q == TO_LAST) begin
                    cnt_q   <= '0;
                    state_q <= HOLD;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                HOLD: if (cnt_q == HOLD_LAST) begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mode        = mode_q;
    assign bus.trig_newd0  = trig0_q;
    assign bus.trig_newd12 = trig12_q;
    assign bus.I_Temp      = disp_q[31:24];
    assign bus.D_Temp      = disp_q[23:16];
    assign bus.I_RH        = disp_q[15:8];
    assign bus.D_RH        = disp_q[7:0];
    assign bus.I_Temp_war  = temp_war_q;
    assign bus.I_Hum_war   = hum_war_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_oled_disp_ctrl.sv
module tb_oled_disp_ctrl;
    localparam int HOLD_CYC    = 6;
    localparam int TIMEOUT_CYC = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;

    oled_disp_ctrl_if ifc();

    oled_disp_ctrl #(
        .DEB_CYC(4), .HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int tot0 = 0, tot12 = 0;
    int trig_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Trigger monitor: counts high cycles of each trigger and logs when they occur.
    always @(negedge clk) begin
        if (ifc.trig_newd0)  begin tot0++;  trig_cyc.push_back(cyc); end
        if (ifc.trig_newd12) begin tot12++; trig_cyc.push_back(cyc); end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic press(input logic [2:0] m);   // {down, up, mode}
        {btn_down, btn_up, btn_mode} = m;
        repeat (2) tick();
        {btn_down, btn_up, btn_mode} = 3'b000;
        repeat (3) tick();
    endtask

    task automatic send(input logic [31:0] v);
        {ifc.s_I_Temp, ifc.s_D_Temp, ifc.s_I_RH, ifc.s_D_RH} = v;
        ifc.sensor_valid = 1'b1;
        tick();
        ifc.sensor_valid = 1'b0;
    endtask

    // Let the controller run for a while, acting as the OLED stage (completes every transfer).
    task automatic settle();
        int bw;
        bw = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (ifc.busy) begin
                if (!ifc.done_send_data) begin
                    if (bw >= 3) ifc.done_send_data = 1'b1;
                    bw++;
                end
            end else begin
                ifc.done_send_data = 1'b0;
                bw = 0;
            end
        end
        ifc.done_send_data = 1'b0;
    endtask

    task automatic check_disp(input string nm, input logic [31:0] v);
        check({nm, "_I_Temp"}, ifc.I_Temp, v[31:24]);
        check({nm, "_D_Temp"}, ifc.D_Temp, v[23:16]);
        check({nm, "_I_RH"},   ifc.I_RH,   v[15:8]);
        check({nm, "_D_RH"},   ifc.D_RH,   v[7:0]);
    endtask

    typedef struct {
        logic [31:0] val;
        bit          trig;
    } svec_t;

    svec_t tbl[6];

    // Reference model state (transaction level).
    int          m_mode, m_req, m_tw, m_hw;
    logic [31:0] m_disp;

    initial begin
        int b0, b12, k, qlen, op;
        bit ref_exp;
        logic [31:0] v;

        tbl[0] = '{32'h19053C03, 1'b1};   // 25/5/60/3
        tbl[1] = '{32'h19053C03, 1'b0};   // same again: no refresh
        tbl[2] = '{32'h19053D03, 1'b1};
        tbl[3] = '{32'h00000000, 1'b1};
        tbl[4] = '{32'h00000000, 1'b0};
        tbl[5] = '{32'hFF0102FE, 1'b1};

        ifc.sensor_valid = 1'b0;
        {ifc.s_I_Temp, ifc.s_D_Temp, ifc.s_I_RH, ifc.s_D_RH} = '0;
        ifc.done_init = 1'b0;
        ifc.done_send_data = 1'b0;

        // ---- reset values ----
        repeat (3) tick();
        check("rst_mode", ifc.mode, 0);
        check("rst_trig0", ifc.trig_newd0, 0);
        check("rst_trig12", ifc.trig_newd12, 0);
        check("rst_busy", ifc.busy, 0);
        check_disp("rst", 32'h0);
        check("rst_twar", ifc.I_Temp_war, 35);
        check("rst_hwar", ifc.I_Hum_war, 80);
        rst_n = 1'b1;

        // ---- first refresh waits for done_init ----
        repeat (20) tick();
        check("init_no_trig_before_done_init", tot0 + tot12, 0);
        check("init_idle_before_done_init", ifc.busy, 0);
        ifc.done_init = 1'b1;
        tick();
        check("init_trig0", ifc.trig_newd0, 1);
        check("init_trig12", ifc.trig_newd12, 0);
        check("init_busy", ifc.busy, 1);
        check("init_mode", ifc.mode, 0);
        check_disp("init", 32'h0);
        tick();
        check("init_trig_one_cycle", ifc.trig_newd0, 0);
        check("init_busy_after_trig", ifc.busy, 1);
        repeat (3) tick();
        check("init_busy_waiting_done", ifc.busy, 1);
        ifc.done_send_data = 1'b1;
        k = 0;
        do begin tick(); k++; end while (ifc.busy && k < 50);
        check("init_hold_len", k, HOLD_CYC + 1);
        ifc.done_send_data = 1'b0;

        // ---- sensor table ----
        for (int i = 0; i < 6; i++) begin
            b0 = tot0;
            send(tbl[i].val);
            tick();
            tick();
            check($sformatf("sv%0d_trig0", i), ifc.trig_newd0, int'(tbl[i].trig));
            check_disp($sformatf("sv%0d", i), tbl[i].val);
            settle();
            check($sformatf("sv%0d_trig_count", i), tot0 - b0, int'(tbl[i].trig));
            check($sformatf("sv%0d_trig12_none", i), tot12, 0);
        end

        // ---- mode press during BUSY ----
        b0 = tot0; b12 = tot12;
        send(32'h01020304);
        tick();
        tick();
        check("modebusy_trig0", ifc.trig_newd0, 1);
        press(3'b001);
        repeat (5) tick();
        check("modebusy_still_busy", ifc.busy, 1);
        check("modebusy_mode_held", ifc.mode, 0);
        ifc.done_send_data = 1'b1;
        k = 0;
        while (ifc.busy && k < 40) begin tick(); k++; end
        check("modebusy_reach_idle", ifc.busy, 0);
        check("modebusy_mode_at_idle", ifc.mode, 0);
        ifc.done_send_data = 1'b0;
        settle();
        check("modebusy_trig12", tot12 - b12, 1);
        check("modebusy_trig0", tot0 - b0, 1);
        check("modebusy_mode1", ifc.mode, 1);

        // ---- threshold saturation ----
        for (int i = 0; i < 30; i++) press(3'b010);
        settle();
        check("twar_sat_max", ifc.I_Temp_war, 60);
        check("hwar_untouched_mode1", ifc.I_Hum_war, 80);
        press(3'b001);
        settle();
        check("mode2", ifc.mode, 2);
        for (int i = 0; i < 85; i++) press(3'b100);
        settle();
        check("hwar_sat_zero", ifc.I_Hum_war, 0);
        check("twar_untouched_mode2", ifc.I_Temp_war, 60);
        b0 = tot0; b12 = tot12;
        press(3'b110);
        settle();
        check("updown_hwar", ifc.I_Hum_war, 0);
        check("updown_twar", ifc.I_Temp_war, 60);
        check("updown_no_trig", (tot0 - b0) + (tot12 - b12), 0);

        // ---- timeout and retrigger ----
        b0 = tot0; b12 = tot12;
        qlen = trig_cyc.size();
        send(32'h09090909);
        k = 0;
        while ((tot12 - b12) < 2 && k < 2 * TIMEOUT_CYC + HOLD_CYC + 20) begin tick(); k++; end
        check("timeout_retrig_count", tot12 - b12, 2);
        check("timeout_no_trig0", tot0 - b0, 0);
        if (trig_cyc.size() >= qlen + 2)
            check("timeout_interval", trig_cyc[qlen+1] - trig_cyc[qlen], TIMEOUT_CYC + HOLD_CYC + 2);
        check("timeout_mode_kept", ifc.mode, 2);
        settle();
        check_disp("timeout", 32'h09090909);

        // ---- reset during TRIG ----
        send(32'h07070707);
        tick();
        tick();
        check("rsttrig_pre_trig12", ifc.trig_newd12, 1);
        rst_n = 1'b0;
        #1;
        check("rsttrig_trig12", ifc.trig_newd12, 0);
        check("rsttrig_trig0", ifc.trig_newd0, 0);
        check("rsttrig_busy", ifc.busy, 0);
        check("rsttrig_mode", ifc.mode, 0);
        check_disp("rsttrig", 32'h0);
        check("rsttrig_twar", ifc.I_Temp_war, 35);
        check("rsttrig_hwar", ifc.I_Hum_war, 80);
        tick();
        rst_n = 1'b1;
        b0 = tot0;
        settle();
        check("rsttrig_reinit_trig0", tot0 - b0, 1);

        // ---- randomized operations against the model ----
        m_mode = 0; m_req = 0; m_tw = 35; m_hw = 80; m_disp = '0;
        for (int n = 0; n < 40; n++) begin
            b0 = tot0; b12 = tot12;
            ref_exp = 1'b0;
            op = int'($urandom_range(0, 4));
            case (op)
                0: begin
                    v = ($urandom_range(0, 1) == 0) ? m_disp : 32'($urandom);
                    if (v != m_disp) ref_exp = 1'b1;
                    send(v);
                end
                1: begin
                    m_req = (m_req + 1) % 3;
                    ref_exp = 1'b1;
                    press(3'b001);
                end
                2: begin
                    if (m_mode == 1 && m_tw < 60) begin m_tw++; ref_exp = 1'b1; end
                    if (m_mode == 2 && m_hw < 99) begin m_hw++; ref_exp = 1'b1; end
                    press(3'b010);
                end
                3: begin
                    if (m_mode == 1 && m_tw > 0) begin m_tw--; ref_exp = 1'b1; end
                    if (m_mode == 2 && m_hw > 0) begin m_hw--; ref_exp = 1'b1; end
                    press(3'b100);
                end
                default: press(3'b110);
            endcase
            if (op == 0) v = v; else v = m_disp;
            if (ref_exp) begin
                m_mode = m_req;
                m_disp = v;
            end
            settle();
            check($sformatf("rnd%0d_trig0", n), tot0 - b0, (ref_exp && m_mode == 0) ? 1 : 0);
            check($sformatf("rnd%0d_trig12", n), tot12 - b12, (ref_exp && m_mode != 0) ? 1 : 0);
            check($sformatf("rnd%0d_mode", n), ifc.mode, m_mode);
            check($sformatf("rnd%0d_twar", n), ifc.I_Temp_war, m_tw);
            check($sformatf("rnd%0d_hwar", n), ifc.I_Hum_war, m_hw);
            check_disp($sformatf("rnd%0d", n), m_disp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
